instr_fetch: RTL
================

# instr_fetch

Instruction fetch and instruction-register stage of the 16-bit processor. It sits directly upstream of the control unit. It owns the program counter, reads one 16-bit instruction word from memory through a request/ready handshake, and latches it into the instruction register. It presents the decoded fields (OP, immediate flag, register indices, sign-extended immediate) to the control unit, holds them until the control unit reports completion, then advances or redirects the PC.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes all state.
- mem_addr  out  16  instruction address (equals pc).
- mem_en  out  1  instruction read request.
- mem_rdata  in  16  instruction word from memory.
- mem_ready  in  1  mem_rdata valid this cycle.
- exec_done  in  1  control unit has finished the current instruction.
- branch_valid  in  1  take branch_target as the next PC; sampled with exec_done.
- branch_target  in  16  redirect address.
- instr_valid  out  1  decoded fields valid.
- OP  out  4  ir[15:12].
- immed  out  1  ir[11].
- rd  out  3  ir[10:8].
- rs1  out  3  ir[7:5].
- rs2  out  3  ir[4:2].
- imm  out  16  ir[7:0] sign-extended.
- pc  out  16  address of the instruction in ir / being fetched.

## Operation
- Registers: state (IDLE, FETCH, ISSUE), pc[15:0], ir[15:0].
- Reset, active while reset=1 at a rising edge:
  - state=IDLE, pc=RESET_PC, ir=16'h0000.
  - Output reset values: mem_en=0, instr_valid=0, mem_addr=RESET_PC, OP/immed/rd/rs1/rs2=0, imm=16'h0000.
- reset takes priority over every other input, including mid-fetch and mid-issue.
- IDLE:
  - mem_en=0, instr_valid=0.
  - en=1 → FETCH.
- FETCH:
  - mem_en=en, mem_addr=pc, instr_valid=0.
  - en=1 and mem_ready=1 → ir<=mem_rdata, go to ISSUE.
  - Otherwise stay in FETCH with mem_en and mem_addr held.
- ISSUE:
  - instr_valid=1, mem_en=0; ir is stable.
  - en=1 and exec_done=1 → go to FETCH. If branch_valid=1, pc<=branch_target; otherwise pc<=pc+1 (word addressed, modulo 2^16, 16'hFFFF wraps to 16'h0000).
- en=0: state, pc and ir hold; mem_en=0; instr_valid keeps its state-derived value. Inputs are ignored that cycle. On re-enable, FETCH reissues the request to the same pc.
- Ignored inputs:
  - mem_ready outside FETCH.
  - exec_done outside ISSUE.
  - branch_valid without exec_done.
  - branch_target when branch_valid=0.
- Decode outputs are combinational from ir only; imm = {{8{ir[7]}}, ir[7:0]}.
- mem_en, mem_addr and instr_valid depend only on registers and en. There is no path from mem_ready, exec_done or branch inputs to any output.

## Timing
- First request: reset released at edge E0. Cycle after E0 is IDLE; with en=1, mem_en=1 from edge E1.
- Fetch latency: ir loads at the edge where mem_ready=1 in FETCH; instr_valid=1 from that edge.
- Zero-wait memory (mem_ready tied 1) with immediate exec_done gives a throughput of 1 instruction per 2 cycles.
- PC update and return to FETCH take effect at the exec_done edge. The next mem_addr shows the new pc in the cycle after that edge.
- mem_rdata must be stable only in the cycle mem_ready=1.
- Control-unit contract: OP/immed/fields stay constant for the whole ISSUE interval. OP changes only on the edge leaving FETCH.

## Test plan
- Reset, RESET_PC=16'h0000, en=1, mem_ready=1, mem_rdata=16'h1A4C → IDLE one cycle, mem_en=1 with mem_addr=0. Next cycle instr_valid=1, OP=1, immed=1, rd=2, rs1=2, rs2=3, imm=16'h004C.
- Wait states: mem_ready low for 3 FETCH cycles, then high with 16'h80F0 → mem_en and mem_addr=pc held 3 cycles. Then OP=8, imm=16'hFFF0.
- Sequential plus wrap: pc=16'hFFFF, exec_done=1, branch_valid=0 → next mem_addr=16'h0000.
- Branch: in ISSUE, exec_done=1, branch_valid=1, branch_target=16'h0040 → next mem_addr=16'h0040. branch_valid=1 with exec_done=0 → no change.
- en=0 for 2 cycles in FETCH and then in ISSUE → mem_en=0, pc/ir/state unchanged, exec_done and mem_ready ignored. On re-enable the fetch is reissued to the same address.
- reset asserted mid-ISSUE with exec_done=1 → pc=RESET_PC, instr_valid=0, ir=0 at that edge. No PC increment.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch / instruction-register stage: owns the PC, fetches one word
// per instruction over a request/ready handshake and presents decoded fields.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        exec_done,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        instr_valid,
    output logic [3:0]  OP,
    output logic        immed,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [15:0] imm,
    output logic [15:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_next;
    logic [15:0] ir;
    logic [15:0] ir_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
        end
    end

    // With en low every branch below falls through to the hold defaults.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        if (en) begin
            unique case (state)
                IDLE: state_next = FETCH;
                FETCH: begin
                    if (mem_ready) begin
                        ir_next    = mem_rdata;
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc_next    = branch_valid ? branch_target : pc + 16'd1;
                        state_next = FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs depend only on registers and en.
    assign mem_addr    = pc;
    assign mem_en      = en && (state == FETCH);
    assign instr_valid = (state == ISSUE);

    assign OP    = ir[15:12];
    assign immed = ir[11];
    assign rd    = ir[10:8];
    assign rs1   = ir[7:5];
    assign rs2   = ir[4:2];
    assign imm   = {{8{ir[7]}}, ir[7:0]};

endmodule
